// File: rtl/sipo_pkg.sv
// sipo_pkg: shared bit-order constants and counter sizing for the SIPO deframer.
package sipo_pkg;

  localparam int unsigned MSB_FIRST_ORDER = 1;
  localparam int unsigned LSB_FIRST_ORDER = 0;

  // Bits needed to count 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: assembly register, bit counter and completion strobe.
// With SIPO_DEFRAMER_PARITY_EN a trailing even-parity bit extends each frame.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = MSB_FIRST_ORDER,
  parameter int unsigned FRAME     = WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             s_in,
  input  logic             load,
  output logic             done,
  output logic [WIDTH-1:0] word,
`ifdef SIPO_DEFRAMER_PARITY_EN
  output logic             par_bad,
`endif
  output logic             busy
);

  localparam int unsigned CW = cnt_width(FRAME);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             last;

  always_comb begin
    if (MSB_FIRST == MSB_FIRST_ORDER) shifted = {shreg[WIDTH-2:0], s_in};
    else                              shifted = {s_in, shreg[WIDTH-1:1]};
  end

  assign last = (count == CW'(FRAME - 1));
  assign done = load && last;
  assign busy = (count != '0);

`ifdef SIPO_DEFRAMER_PARITY_EN
  // The parity bit is the final sample and never enters the data register.
  assign word    = shreg;
  assign par_bad = (^shreg) ^ s_in;
`else
  assign word    = shifted;
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count <= '0;
      shreg <= '0;
    end else if (load) begin
      count <= last ? '0 : count + 1'b1;
`ifdef SIPO_DEFRAMER_PARITY_EN
      if (count < CW'(WIDTH)) shreg <= shifted;
`else
      shreg <= shifted;
`endif
    end
  end

endmodule

// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-to-parallel receiver with valid/ready holding stage and sticky overrun.
// Define SIPO_DEFRAMER_PARITY_EN to expect an even-parity bit after each word (adds parity_err).
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             s_in,
  input  logic             load,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             overrun,
  output logic             busy
`ifdef SIPO_DEFRAMER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
  logic par_bad;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  logic             done;
  logic [WIDTH-1:0] word;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .FRAME     (FRAME)
  ) u_core (
    .clk     (clk),
    .clear   (clear),
    .s_in    (s_in),
    .load    (load),
    .done    (done),
    .word    (word),
`ifdef SIPO_DEFRAMER_PARITY_EN
    .par_bad (par_bad),
`endif
    .busy    (busy)
  );

  // A completing word wins over an accept on the same edge; it is dropped only if the slot stays full.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      p_out      <= '0;
      p_valid    <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (done) begin
      if (!p_valid || p_ready) begin
        p_out      <= word;
        p_valid    <= 1'b1;
`ifdef SIPO_DEFRAMER_PARITY_EN
        parity_err <= par_bad;
`endif
      end else begin
        overrun    <= 1'b1;
      end
    end else if (p_valid && p_ready) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_deframer.sv
// tb_sipo_deframer: directed and random checks of MSB- and LSB-first deframers against a queue model.
// Parity checks are included when SIPO_DEFRAMER_PARITY_EN is defined.
module tb_sipo_deframer;

  localparam int unsigned W = 8;
`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int unsigned FRAME = W + 1;
`else
  localparam int unsigned FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         clear, s_in, load, p_ready;
  logic [W-1:0] p_out_m, p_out_l;
  logic         valid_m, valid_l, over_m, over_l, busy_m, busy_l;
`ifdef SIPO_DEFRAMER_PARITY_EN
  logic         perr_m, perr_l;
`endif

  int checks = 0;
  int errors = 0;

  bit           bq[$];
  logic [W-1:0] e_m, e_l;
  logic         e_valid, e_over, e_perr;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .clear(clear), .s_in(s_in), .load(load),
    .p_out(p_out_m), .p_valid(valid_m), .p_ready(p_ready),
    .overrun(over_m), .busy(busy_m)
`ifdef SIPO_DEFRAMER_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .clear(clear), .s_in(s_in), .load(load),
    .p_out(p_out_l), .p_valid(valid_l), .p_ready(p_ready),
    .overrun(over_l), .busy(busy_l)
`ifdef SIPO_DEFRAMER_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    e_m = '0; e_l = '0; e_valid = 1'b0; e_over = 1'b0; e_perr = 1'b0;
  endtask

  // One posedge of the reference: frame bits collect in a queue, completed frames go to a one-deep slot.
  task automatic model_edge(input logic l, input logic s, input logic r);
    logic [W-1:0] wm, wl;
    logic         px, done, acc;
    acc  = e_valid && r;
    done = 1'b0;
    wm = '0; wl = '0; px = 1'b0;
    if (l) begin
      bq.push_back(s);
      if (bq.size() == FRAME) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = bq[i];
          wl[i]     = bq[i];
        end
        for (int i = 0; i < FRAME; i++) px = px ^ bq[i];
        bq.delete();
      end
    end
    if (done) begin
      if (!e_valid || r) begin
        e_m = wm; e_l = wl; e_perr = px; e_valid = 1'b1;
      end else begin
        e_over = 1'b1;
      end
    end else if (acc) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".p_out_msb"}, 32'(p_out_m), 32'(e_m));
    chk({tag, ".p_out_lsb"}, 32'(p_out_l), 32'(e_l));
    chk({tag, ".p_valid"}, {30'd0, valid_m, valid_l}, {30'd0, e_valid, e_valid});
    chk({tag, ".overrun"}, {30'd0, over_m, over_l}, {30'd0, e_over, e_over});
    chk({tag, ".busy"}, {30'd0, busy_m, busy_l}, {30'd0, bq.size() != 0, bq.size() != 0});
`ifdef SIPO_DEFRAMER_PARITY_EN
    chk({tag, ".parity_err"}, {30'd0, perr_m, perr_l}, {30'd0, e_perr, e_perr});
`endif
  endtask

  // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
  task automatic step(input logic l, input logic s, input logic r, input string tag);
    load = l; s_in = s; p_ready = r;
    @(posedge clk);
    model_edge(l, s, r);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic pbit,
                            input logic r_rest, input logic r_last, input string tag);
    for (int i = 0; i < FRAME; i++) begin
      if (i < W) step(1'b1, w[W-1-i], (i == FRAME - 1) ? r_last : r_rest, tag);
      else       step(1'b1, pbit, r_last, tag);
    end
  endtask

  initial begin
    logic [W-1:0] d2;
    d2 = 8'hD2;
    clear = 1'b0; load = 1'b0; s_in = 1'b0; p_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.p_valid_const", {31'd0, valid_m}, 32'd0);
    @(negedge clk);
    clear = 1'b1;

    // Basic word with consumer ready.
    send_frame(d2, ^d2, 1'b1, 1'b1, "d2");
    chk("d2.msb_word", 32'(p_out_m), 32'hD2);
    chk("d2.lsb_word", 32'(p_out_l), 32'h4B);
    chk("d2.valid_set", {31'd0, valid_m}, 32'd1);
    step(1'b0, 1'b0, 1'b1, "d2.after");
    chk("d2.valid_one_cycle", {31'd0, valid_m}, 32'd0);
    chk("d2.no_overrun", {31'd0, over_m}, 32'd0);

    // Gap of three idle cycles after the fourth bit.
    for (int i = 0; i < 4; i++) step(1'b1, d2[W-1-i], 1'b1, "gap.head");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, "gap.idle");
      chk("gap.busy", {31'd0, busy_m}, 32'd1);
    end
    for (int i = 4; i < FRAME; i++) step(1'b1, (i < W) ? d2[W-1-i] : ^d2, 1'b1, "gap.tail");
    chk("gap.word", 32'(p_out_m), 32'hD2);
    step(1'b0, 1'b0, 1'b1, "gap.drain");

    // Accept of 3C coincides with completion of A5.
    send_frame(8'h3C, ^8'h3C, 1'b1, 1'b1, "b2b.first");
    send_frame(8'hA5, ^8'hA5, 1'b0, 1'b1, "b2b.second");
    chk("b2b.valid", {31'd0, valid_m}, 32'd1);
    chk("b2b.word", 32'(p_out_m), 32'hA5);
    chk("b2b.no_overrun", {31'd0, over_m}, 32'd0);
    step(1'b0, 1'b0, 1'b1, "b2b.drain");

    // Overrun with a stalled consumer.
    send_frame(d2, ^d2, 1'b0, 1'b0, "ovr.first");
    send_frame(8'h0F, ^8'h0F, 1'b0, 1'b0, "ovr.second");
    chk("ovr.word_kept", 32'(p_out_m), 32'hD2);
    chk("ovr.flag", {31'd0, over_m}, 32'd1);
    step(1'b0, 1'b0, 1'b1, "ovr.accept");
    chk("ovr.valid_fall", {31'd0, valid_m}, 32'd0);
    chk("ovr.sticky", {31'd0, over_m}, 32'd1);

    // Asynchronous reset mid-word while a word is held and overrun is set.
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0, "rst.fill");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "rst.partial");
    chk("rst.pre_valid", {31'd0, valid_m}, 32'd1);
    #2 clear = 1'b0;
    #1;
    model_reset();
    check_all("rst.async");
    chk("rst.p_out_zero", 32'(p_out_m), 32'd0);
    @(negedge clk);
    check_all("rst.held");
    clear = 1'b1;

`ifdef SIPO_DEFRAMER_PARITY_EN
    send_frame(d2, 1'b0, 1'b1, 1'b1, "par.good");
    chk("par.good_flag", {31'd0, perr_m}, 32'd0);
    step(1'b0, 1'b0, 1'b1, "par.drain1");
    send_frame(d2, 1'b1, 1'b1, 1'b1, "par.bad");
    chk("par.bad_flag", {31'd0, perr_m}, 32'd1);
    chk("par.bad_word", 32'(p_out_m), 32'hD2);
    step(1'b0, 1'b0, 1'b1, "par.drain2");
`endif

    // Random traffic with varying load density and consumer readiness.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
